// File: rtl/upc_pkg.sv
// Shared types and code constants for the U/P/C scanner front end.
package upc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } upc_state_t;

    localparam logic [2:0] BLANK_CODE     = 3'b111;
    localparam logic [2:0] NO_ITEM_CODE_A = 3'b010;
    localparam logic [2:0] NO_ITEM_CODE_B = 3'b111;

    function automatic logic is_no_item(input logic [2:0] code);
        return (code == NO_ITEM_CODE_A) || (code == NO_ITEM_CODE_B);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces the active-low scan key and emits a one-cycle
// strobe when the debounced level goes from released to pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic din_n,
    output logic press_pulse
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_n;
    logic             sync2_n;
    logic             deb_n;
    logic             deb_prev_n;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       settle;
    logic             armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_n <= 1'b1;
            sync2_n <= 1'b1;
        end else begin
            sync1_n <= din_n;
            sync2_n <= sync1_n;
        end
    end

    // Mismatch run counter; the accepted level flips once the run reaches the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            deb_n <= 1'b1;
        end else if (sync2_n == deb_n) begin
            cnt <= '0;
        end else if (cnt >= CNT_LAST) begin
            deb_n <= sync2_n;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Presses count only after the key has been seen released once the
    // synchronizer holds real samples, so a key held through reset is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_prev_n  <= 1'b1;
            settle      <= 2'd0;
            armed       <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            deb_prev_n <= deb_n;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            armed       <= armed | ((settle == 2'd2) & sync2_n & deb_n);
            press_pulse <= armed & ~deb_n & deb_prev_n;
        end
    end

endmodule

// File: rtl/upc_scanner.sv
// Captures the synchronized item code on each debounced scan press and holds
// it for a fixed time before blanking the display code.
module upc_scanner
    import upc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 250000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw_upc,
    input  logic       scan_n,
    output logic       U,
    output logic       P,
    output logic       C,
    output logic       upc_valid,
    output logic       scan_pulse,
    output logic       invalid_code
);

    localparam int                HOLD_W    = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [2:0]        sw_sync1;
    logic [2:0]        sw_sync2;
    logic              press;
    upc_state_t        state;
    upc_state_t        state_next;
    logic [2:0]        code;
    logic [2:0]        code_next;
    logic              valid_next;
    logic              pulse_next;
    logic              invalid_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync1 <= 3'b000;
            sw_sync2 <= 3'b000;
        end else begin
            sw_sync1 <= sw_upc;
            sw_sync2 <= sw_sync1;
        end
    end

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk        (clk),
        .reset      (reset),
        .din_n      (scan_n),
        .press_pulse(press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            code         <= BLANK_CODE;
            upc_valid    <= 1'b0;
            scan_pulse   <= 1'b0;
            invalid_code <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            state        <= state_next;
            code         <= code_next;
            upc_valid    <= valid_next;
            scan_pulse   <= pulse_next;
            invalid_code <= invalid_next;
            hold_cnt     <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (press) state_next = SHOW;
            SHOW: if (!press && hold_cnt >= HOLD_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A press always wins over the hold timeout in the same cycle.
    always_comb begin
        code_next  = code;
        valid_next = upc_valid;
        pulse_next = 1'b0;
        hold_next  = hold_cnt;
        if (press) begin
            code_next  = sw_sync2;
            valid_next = 1'b1;
            pulse_next = 1'b1;
            hold_next  = '0;
        end else if (state == SHOW) begin
            if (hold_cnt >= HOLD_LAST) begin
                code_next  = BLANK_CODE;
                valid_next = 1'b0;
                hold_next  = '0;
            end else begin
                hold_next = hold_cnt + 1'b1;
            end
        end
        invalid_next = valid_next & is_no_item(code_next);
    end

    assign {U, P, C} = code;

endmodule

// File: tb/tb_upc_scanner.sv
// Bench for upc_scanner: vector table, directed corner sequences and random
// key/switch traffic against a window/timestamp reference model.
module tb_upc_scanner;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int MAXN = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sw_upc;
    logic       scan_n;
    logic       U, P, C, upc_valid, scan_pulse, invalid_code;
    logic [5:0] dut_vec;

    always #5 clk = ~clk;

    upc_scanner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_upc      (sw_upc),
        .scan_n      (scan_n),
        .U           (U),
        .P           (P),
        .C           (C),
        .upc_valid   (upc_valid),
        .scan_pulse  (scan_pulse),
        .invalid_code(invalid_code)
    );

    assign dut_vec = {U, P, C, upc_valid, scan_pulse, invalid_code};

    int total = 0;
    int bad   = 0;

    // Reference model: raw history per edge since reset release.
    bit         rawk [MAXN];
    logic [2:0] raws [MAXN];
    bit         s2k  [MAXN];
    bit         debh [MAXN];
    bit         roseh[MAXN];
    bit         armh [MAXN];
    int         n, last_tog, cap;
    bit         debm, armed, have, exp_pulse;
    logic [2:0] mcode;
    int         pulses_dut;

    typedef struct {
        logic [2:0] sw;
        logic       key;
        int         cycles;
        logic [5:0] exp;
    } vec_t;
    vec_t vt[10];

    function automatic logic [5:0] model_vec();
        logic [2:0] c;
        c = have ? mcode : 3'b111;
        return {c, have, exp_pulse, have && (c == 3'b010 || c == 3'b111)};
    endfunction

    task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got={upc,v,p,inv}=%b expected=%b", nm, n, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; last_tog = 0; cap = 0;
        s2k[0] = 1'b1; debh[0] = 1'b1; roseh[0] = 1'b0; armh[0] = 1'b0;
        debm = 1'b1; armed = 1'b0; have = 1'b0; exp_pulse = 1'b0;
        mcode = 3'b111;
    endtask

    task automatic model_edge();
        bit tog;
        n++;
        if (n >= MAXN) begin
            $display("FAIL model_history edge=%0d got=overflow expected=<%0d", n, MAXN);
            $fatal(1, "history overflow");
        end
        rawk[n] = scan_n;
        raws[n] = sw_upc;
        s2k[n]  = (n >= 2) ? rawk[n-1] : 1'b1;
        // Accepted key level flips when the last DEB synchronized samples since
        // the previous flip all disagree with it.
        tog = (n - DEB >= last_tog);
        for (int j = 1; j <= DEB; j++) begin
            if (tog && s2k[n-j] == debm) tog = 0;
        end
        roseh[n] = 1'b0;
        if (tog) begin
            debm     = !debm;
            last_tog = n;
            roseh[n] = (debm == 1'b0);
        end
        debh[n] = debm;
        if (n - 1 >= 2 && s2k[n-1] && debh[n-1]) armed = 1'b1;
        armh[n] = armed;
        exp_pulse = 1'b0;
        if (n >= 2 && roseh[n-2] && armh[n-2]) begin
            exp_pulse = 1'b1;
            have      = 1'b1;
            cap       = n;
            mcode     = raws[n-2];
        end
        if (have && (n - cap) >= HOLD) have = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cycle", dut_vec, model_vec());
        if (scan_pulse) pulses_dut++;
    endtask

    task automatic wait_pulse(input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            got = scan_pulse;
        end
        check_int(nm, got, 1);
    endtask

    task automatic valid_len(input string nm);
        int len;
        len = 0;
        while (upc_valid && len < 60) begin
            step();
            len++;
        end
        check_int(nm, len, HOLD);
    endtask

    task automatic idle_release(input int cycles);
        scan_n = 1'b1;
        repeat (cycles) step();
    endtask

    initial begin
        int p0;
        pulses_dut = 0;
        vt[0] = '{3'b101, 1'b1, 3,  6'b111_0_0_0};
        vt[1] = '{3'b011, 1'b1, 3,  6'b111_0_0_0};
        vt[2] = '{3'b100, 1'b1, 2,  6'b111_0_0_0};
        vt[3] = '{3'b100, 1'b0, 7,  6'b111_0_0_0};
        vt[4] = '{3'b100, 1'b0, 1,  6'b100_1_1_0};
        vt[5] = '{3'b100, 1'b0, 1,  6'b100_1_0_0};
        vt[6] = '{3'b100, 1'b0, 17, 6'b100_1_0_0};
        vt[7] = '{3'b100, 1'b0, 1,  6'b100_1_0_0};
        vt[8] = '{3'b100, 1'b0, 1,  6'b111_0_0_0};
        vt[9] = '{3'b100, 1'b0, 10, 6'b111_0_0_0};

        reset  = 1'b1;
        sw_upc = 3'b101;
        scan_n = 1'b1;
        model_reset();
        #1;
        check("reset_state", dut_vec, 6'b111_0_0_0);
        repeat (3) @(negedge clk);
        check("reset_held", dut_vec, 6'b111_0_0_0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            sw_upc = vt[i].sw;
            scan_n = vt[i].key;
            repeat (vt[i].cycles) step();
            check($sformatf("vec%0d", i), dut_vec, vt[i].exp);
        end

        // Bounce: single-cycle pulses never reach the debounce window.
        idle_release(30);
        p0 = pulses_dut;
        for (int i = 0; i < 12; i++) begin
            scan_n = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
        end
        check_int("bounce_quiet", pulses_dut - p0, 0);
        scan_n = 1'b0;
        repeat (DEB + 2) step();
        check_int("bounce_early", pulses_dut - p0, 0);
        step();
        check_int("bounce_one", pulses_dut - p0, 1);
        check("bounce_code", dut_vec, 6'b100_1_1_0);

        // Timeout with the key held down.
        idle_release(30);
        sw_upc = 3'b011;
        scan_n = 1'b0;
        wait_pulse("timeout_capture");
        check("timeout_code", dut_vec, 6'b011_1_1_0);
        valid_len("timeout_len");
        p0 = pulses_dut;
        repeat (15) step();
        check_int("timeout_no_repulse", pulses_dut - p0, 0);
        check("timeout_blank", dut_vec, 6'b111_0_0_0);

        // Re-scan inside the hold window with a new switch code.
        idle_release(30);
        sw_upc = 3'b001;
        scan_n = 1'b0;
        wait_pulse("rescan_first");
        idle_release(7);
        sw_upc = 3'b110;
        scan_n = 1'b0;
        wait_pulse("rescan_second");
        check("rescan_code", dut_vec, 6'b110_1_1_0);
        valid_len("rescan_len");

        // No-item code, then asynchronous reset with the key held through it.
        idle_release(30);
        sw_upc = 3'b010;
        scan_n = 1'b0;
        wait_pulse("invalid_capture");
        step();
        check("invalid_flag", dut_vec, 6'b010_1_0_1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", dut_vec, 6'b111_0_0_0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        p0 = pulses_dut;
        repeat (30) step();
        check_int("held_through_reset", pulses_dut - p0, 0);
        idle_release(10);
        sw_upc = 3'b110;
        scan_n = 1'b0;
        wait_pulse("after_reset_capture");
        check("after_reset_code", dut_vec, 6'b110_1_1_0);

        // Random key runs and switch changes.
        idle_release(10);
        for (int r = 0; r < 220; r++) begin
            int len;
            len = $urandom_range(1, 14);
            scan_n = $urandom_range(0, 1);
            if ($urandom_range(0, 2) == 0) sw_upc = 3'($urandom_range(0, 7));
            repeat (len) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
